// File: rtl/rd_fwft_buf.sv
// rtl/rd_fwft_buf.sv - first-word-fall-through output stage for the async FIFO read side
//
// Pulls words from the FIFO read port on its own (rd_en), follows each read
// through the memory read latency, and parks returned words in a small ordered
// buffer whose head is presented as a valid/ready stream with registered outputs.
// rd_en is derived from registered credit state and rd_empty only, so there is
// no combinational path from out_ready back to the FIFO.
//
// Parameters:
//   DATASIZE   - FIFO word width
//   RD_LATENCY - memory read latency, 0 (async read) or 1 (registered read)
//
// Ports:
//   rd_clk    in   1         read-domain clock
//   rd_rst    in   1         synchronous active-high reset
//   rd_empty  in   1         registered empty flag from the read-pointer logic
//   rd_en     out  1         read request to the read-pointer logic and memory
//   rd_data   in   DATASIZE  memory read data, valid RD_LATENCY cycles after rd_en
//   out_valid out  1         head word is presented
//   out_ready in   1         consumer accepts the head word
//   out_data  out  DATASIZE  head word
//   buf_level out  2         words held in the buffer, excluding reads in flight

`timescale 1ns/1ps

module rd_fwft_buf #(
  parameter int DATASIZE   = 8,
  parameter int RD_LATENCY = 0
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_empty,
  output logic                rd_en,
  input  logic [DATASIZE-1:0] rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic [1:0]          buf_level
);

  // One entry per cycle of credit round-trip: the read latency plus the
  // capture edge plus the pop edge.
  localparam int              DEPTH    = RD_LATENCY + 2;
  localparam int              IDXW     = (DEPTH > 2) ? 2 : 1;
  localparam logic [1:0]      DEPTH_C  = 2'(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  logic [1:0]          r_cnt;        // buffered words + reads in flight
  logic [1:0]          r_level;      // buffered words only
  logic                r_valid;
  logic [IDXW-1:0]     r_wr_idx;
  logic [IDXW-1:0]     r_rd_idx;
  logic [DATASIZE-1:0] r_mem [DEPTH];

  logic       w_rd_en;
  logic       w_cap;
  logic       w_pop;
  logic [1:0] w_cnt_next;
  logic [1:0] w_level_next;

  function automatic logic [IDXW-1:0] f_next_idx(input logic [IDXW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Credits only: a read is issued whenever a buffer slot is guaranteed to be
  // free when its data returns.
  assign w_rd_en = !rd_rst && !rd_empty && (r_cnt < DEPTH_C);
  assign w_pop   = r_valid && out_ready;

  assign rd_en     = w_rd_en;
  assign out_valid = r_valid;
  assign out_data  = r_mem[r_rd_idx];
  assign buf_level = r_level;

  // Capture strobe: the read issue itself for async memory, or the issue
  // delayed by one cycle for registered memory.
  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign w_cap = w_rd_en;
    end else begin : g_lat1
      logic r_inflight;
      always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
          r_inflight <= 1'b0;
        end else begin
          r_inflight <= w_rd_en;
        end
      end
      assign w_cap = r_inflight;
    end
  endgenerate

  always_comb begin
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    case ({w_rd_en, w_pop})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
    case ({w_cap, w_pop})
      2'b10:   w_level_next = r_level + 2'd1;
      2'b01:   w_level_next = r_level - 2'd1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_cnt    <= 2'd0;
      r_level  <= 2'd0;
      r_valid  <= 1'b0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      // Registered valid tracks the next level so out_valid has no logic
      // after the flop.
      r_valid <= (w_level_next != 2'd0);
      // The write slot never aliases the head while it is presented, because
      // credits keep the buffer from filling past DEPTH.
      if (w_cap) begin
        r_mem[r_wr_idx] <= rd_data;
        r_wr_idx        <= f_next_idx(r_wr_idx);
      end
      if (w_pop) begin
        r_rd_idx <= f_next_idx(r_rd_idx);
      end
    end
  end

  always @(posedge rd_clk) begin
    if (!rd_rst) begin
      a_no_overflow: assert (!(w_cap && (r_level == DEPTH_C)));
      a_cnt_bound:   assert (r_cnt <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_rd_fwft_buf.sv
// tb/tb_rd_fwft_buf.sv - directed and scoreboard bench for rd_fwft_buf at both read latencies

`timescale 1ns/1ps

module tb_rd_fwft_buf;

  typedef struct {
    logic       ready;
    logic       exp_en;
    logic       exp_valid;
    logic [1:0] exp_level;
    logic [7:0] exp_data;
  } vec_t;

  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic        rst   [2];
  logic        empty [2];
  logic        en    [2];
  logic [7:0]  rdat  [2];
  logic        vld   [2];
  logic        rdy   [2];
  logic [7:0]  odat  [2];
  logic [1:0]  lvl   [2];

  logic [7:0]  fmem  [2][1024];
  logic [10:0] rptr  [2];
  logic [10:0] wptr  [2];
  logic [7:0]  rdq1;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl [15];

  rd_fwft_buf #(.DATASIZE(8), .RD_LATENCY(0)) u_lat0 (
    .rd_clk(rd_clk), .rd_rst(rst[0]), .rd_empty(empty[0]), .rd_en(en[0]),
    .rd_data(rdat[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
    .out_data(odat[0]), .buf_level(lvl[0])
  );

  rd_fwft_buf #(.DATASIZE(8), .RD_LATENCY(1)) u_lat1 (
    .rd_clk(rd_clk), .rd_rst(rst[1]), .rd_empty(empty[1]), .rd_en(en[1]),
    .rd_data(rdat[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
    .out_data(odat[1]), .buf_level(lvl[1])
  );

  // FIFO read-side model: registered pointers, async memory for latency 0,
  // registered read data for latency 1.
  always_comb begin
    empty[0] = (rptr[0] == wptr[0]);
    empty[1] = (rptr[1] == wptr[1]);
    rdat[0]  = fmem[0][rptr[0][9:0]];
    rdat[1]  = rdq1;
  end

  always @(posedge rd_clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst[l]) rptr[l] <= '0;
      else if (en[l]) rptr[l] <= rptr[l] + 11'd1;
    end
    if (en[1]) rdq1 <= fmem[1][rptr[1][9:0]];
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int l, input int nw);
    rst[l]  = 1'b1;
    wptr[l] = 11'(nw);
    step();
    @(negedge rd_clk);
    chk($sformatf("lat%0d_reset_rd_en", l), {31'd0, en[l]}, 0);
    chk($sformatf("lat%0d_reset_valid", l), {31'd0, vld[l]}, 0);
    chk($sformatf("lat%0d_reset_data", l), {24'd0, odat[l]}, 0);
    step();
    rst[l] = 1'b0;
  endtask

  task automatic stream(input int l);
    int fe, fv, cyc;
    for (int i = 0; i < 8; i++) fmem[l][i] = 8'(i + 1);
    rdy[l] = 1'b1;
    do_reset(l, 8);
    fe = -1; fv = -1; cyc = 0;
    while (fv < 0 && cyc < 20) begin
      @(negedge rd_clk);
      if (en[l] && fe < 0) fe = cyc;
      if (vld[l]) fv = cyc;
      else begin
        step();
        cyc++;
      end
    end
    chk($sformatf("lat%0d_first_valid_seen", l), {31'd0, fv >= 0}, 1);
    chk($sformatf("lat%0d_first_valid_delay", l), 32'(fv - fe), 32'(l + 1));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        step();
        @(negedge rd_clk);
      end
      chk($sformatf("lat%0d_stream_valid_%0d", l, k), {31'd0, vld[l]}, 1);
      chk($sformatf("lat%0d_stream_data_%0d", l, k), {24'd0, odat[l]}, 32'(k + 1));
    end
    step();
    rdy[l] = 1'b0;
  endtask

  task automatic rand_run(input int l);
    int  exp_idx, occ, cyc;
    logic       prev_stall;
    logic [7:0] prev_data;
    for (int i = 0; i < 1000; i++) fmem[l][i] = 8'($urandom);
    rdy[l] = 1'b0;
    do_reset(l, 0);
    exp_idx = 0; occ = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (exp_idx < 1000 && cyc < 20000) begin
      if (wptr[l] < 11'd1000 && $urandom_range(0, 2) != 0) wptr[l] = wptr[l] + 11'd1;
      rdy[l] = 1'($urandom_range(0, 1));
      @(negedge rd_clk);
      if (prev_stall) begin
        chk($sformatf("lat%0d_stall_valid", l), {31'd0, vld[l]}, 1);
        chk($sformatf("lat%0d_stall_data", l), {24'd0, odat[l]}, {24'd0, prev_data});
      end
      chk($sformatf("lat%0d_credit_bound", l), {31'd0, occ <= l + 2}, 1);
      chk($sformatf("lat%0d_level_bound", l), {31'd0, int'(lvl[l]) <= l + 2}, 1);
      if (vld[l] && rdy[l]) begin
        chk($sformatf("lat%0d_rand_data_%0d", l, exp_idx), {24'd0, odat[l]},
            {24'd0, fmem[l][exp_idx]});
        exp_idx++;
      end
      occ = occ + int'(en[l]) - int'(vld[l] && rdy[l]);
      prev_stall = vld[l] && !rdy[l];
      prev_data  = odat[l];
      step();
      cyc++;
    end
    chk($sformatf("lat%0d_rand_words_done", l), 32'(exp_idx), 1000);
    rdy[l] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, cyc;
    // Latency-1 backpressure then release, FIFO preloaded with 0x11..0x18.
    //           ready  rd_en  valid  level  data
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h11};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'h11};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'h11};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h11};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'h12};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h13};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h14};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h15};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h16};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h17};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h18};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

    rst[0] = 1'b1; rst[1] = 1'b1;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    wptr[0] = '0;  wptr[1] = '0;
    step();

    // Idle after reset with an empty FIFO.
    do_reset(0, 0);
    do_reset(1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk);
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("lat%0d_idle_rd_en", l), {31'd0, en[l]}, 0);
        chk($sformatf("lat%0d_idle_valid", l), {31'd0, vld[l]}, 0);
        chk($sformatf("lat%0d_idle_level", l), {30'd0, lvl[l]}, 0);
        chk($sformatf("lat%0d_idle_data", l), {24'd0, odat[l]}, 0);
      end
      step();
    end

    stream(0);
    stream(1);

    for (int i = 0; i < 8; i++) fmem[1][i] = 8'h11 + 8'(i);
    do_reset(1, 8);
    for (int r = 0; r < 15; r++) begin
      rdy[1] = tbl[r].ready;
      @(negedge rd_clk);
      chk($sformatf("bp_rd_en_%0d", r), {31'd0, en[1]}, {31'd0, tbl[r].exp_en});
      chk($sformatf("bp_valid_%0d", r), {31'd0, vld[1]}, {31'd0, tbl[r].exp_valid});
      chk($sformatf("bp_level_%0d", r), {30'd0, lvl[1]}, {30'd0, tbl[r].exp_level});
      if (tbl[r].exp_valid)
        chk($sformatf("bp_data_%0d", r), {24'd0, odat[1]}, {24'd0, tbl[r].exp_data});
      step();
    end
    rdy[1] = 1'b0;

    // Reset while two words are buffered and one read is in flight.
    for (int i = 0; i < 8; i++) fmem[1][i] = 8'h21 + 8'(i);
    do_reset(1, 8);
    step(); step(); step();
    @(negedge rd_clk);
    chk("rstmid_pre_level", {30'd0, lvl[1]}, 2);
    rst[1]  = 1'b1;
    wptr[1] = '0;
    #1;
    chk("rstmid_rd_en_in_reset", {31'd0, en[1]}, 0);
    step();
    rst[1] = 1'b0;
    @(negedge rd_clk);
    chk("rstmid_valid_after", {31'd0, vld[1]}, 0);
    chk("rstmid_level_after", {30'd0, lvl[1]}, 0);
    step();
    rdy[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      chk($sformatf("rstmid_no_stale_%0d", c), {31'd0, vld[1]}, 0);
      step();
    end
    fmem[1][0] = 8'hA1;
    wptr[1]    = 11'd1;
    fv = 0; cyc = 0;
    while (!fv && cyc < 10) begin
      @(negedge rd_clk);
      if (vld[1]) fv = 1;
      else begin
        step();
        cyc++;
      end
    end
    chk("rstmid_new_word_seen", 32'(fv), 1);
    chk("rstmid_new_word_data", {24'd0, odat[1]}, 32'hA1);
    step();
    rdy[1] = 1'b0;

    rand_run(0);
    rand_run(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
